// File: rtl/dcache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int SETS     = 16;
  localparam int WORDS    = 4;
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: data/tag arrays (never cleared) plus valid/dirty bits cleared on reset.
// Combinational read of one whole line; one word written per cycle, metadata written alongside.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int SETS  = dcache_pkg::SETS,
  parameter int WORDS = dcache_pkg::WORDS,
  parameter int TAG_W = dcache_pkg::TAG_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [$clog2(SETS)-1:0]       rd_index,
  output logic [TAG_W-1:0]              rd_tag,
  output logic                          rd_valid,
  output logic                          rd_dirty,
  output logic [WORDS-1:0][31:0]        rd_words,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_index,
  input  logic [$clog2(WORDS)-1:0]      wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          meta_we,
  input  logic [TAG_W-1:0]              meta_tag,
  input  logic                          meta_dirty
);

  logic [WORDS-1:0][31:0] data_q [SETS];
  logic [TAG_W-1:0]       tag_q  [SETS];
  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;

  always_ff @(posedge clock) begin
    if (wr_en)   data_q[wr_index][wr_word] <= wr_data;
    if (meta_we) tag_q[wr_index]           <= meta_tag;
  end

  // Any metadata write marks the line valid; only dirty differs between store-hit and refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= meta_dirty;
    end
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_words = data_q[rd_index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: 0-latency hits, stall on miss until refill.
// Memory side holds each word request until ram_ack; dirty victims are written back before refill.
module data_cache_controller
  import dcache_pkg::*;
#(
  parameter int SETS  = dcache_pkg::SETS,
  parameter int WORDS = dcache_pkg::WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cache_stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TG_W  = 32 - IDX_W - OFF_W - 2;

  state_t                 state_q, state_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic [TG_W-1:0]        miss_tag_q;
  logic [IDX_W-1:0]       miss_idx_q;

  logic [TG_W-1:0]        cpu_tag;
  logic [IDX_W-1:0]       cpu_idx;
  logic [OFF_W-1:0]       cpu_word;
  logic                   access, hit, miss, last_word;
  logic                   unused_addr_bits;

  logic [IDX_W-1:0]       rd_index;
  logic [TG_W-1:0]        rd_tag;
  logic                   rd_valid, rd_dirty;
  logic [WORDS-1:0][31:0] rd_words;
  logic                   wr_en, meta_we, meta_dirty;
  logic [OFF_W-1:0]       wr_word;
  logic [31:0]            wr_data;
  logic [TG_W-1:0]        meta_tag;

  assign cpu_tag          = cpu_addr[31 -: TG_W];
  assign cpu_idx          = cpu_addr[OFF_W+2 +: IDX_W];
  assign cpu_word         = cpu_addr[2 +: OFF_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Outside IDLE the array is addressed by the latched miss, so cpu_* may wander freely.
  assign rd_index  = (state_q == IDLE) ? cpu_idx : miss_idx_q;
  assign access    = cpu_read | cpu_write;
  assign hit       = (state_q == IDLE) && rd_valid && (rd_tag == cpu_tag);
  assign miss      = (state_q == IDLE) && access && !hit;
  assign last_word = (cnt_q == OFF_W'(WORDS - 1));

  dcache_line_array #(.SETS(SETS), .WORDS(WORDS), .TAG_W(TG_W)) u_lines (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (rd_index),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_words   (rd_words),
    .wr_en      (wr_en),
    .wr_index   (rd_index),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .meta_we    (meta_we),
    .meta_tag   (meta_tag),
    .meta_dirty (meta_dirty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && miss) begin
      miss_tag_q <= cpu_tag;
      miss_idx_q <= cpu_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_rdata   = '0;
    cache_stall = 1'b0;
    ram_req     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    wr_en       = 1'b0;
    wr_word     = cpu_word;
    wr_data     = cpu_wdata;
    meta_we     = 1'b0;
    meta_tag    = cpu_tag;
    meta_dirty  = 1'b1;
    case (state_q)
      IDLE: begin
        if (access && hit) begin
          cpu_rdata = rd_words[cpu_word];
          if (cpu_write) begin
            wr_en   = 1'b1;
            meta_we = 1'b1;
          end
        end else if (access) begin
          cache_stall = 1'b1;
          cnt_d       = '0;
          state_d     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cache_stall = 1'b1;
        ram_req     = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = {rd_tag, miss_idx_q, cnt_q, 2'b00};
        ram_wdata   = rd_words[cnt_q];
        if (ram_ack) begin
          cnt_d = last_word ? '0 : cnt_q + 1'b1;
          if (last_word) state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        cache_stall = 1'b1;
        ram_req     = 1'b1;
        ram_addr    = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
        if (ram_ack) begin
          wr_en   = 1'b1;
          wr_word = cnt_q;
          wr_data = ram_rdata;
          cnt_d   = last_word ? '0 : cnt_q + 1'b1;
          // Tag/valid flip only with the last word so the retry hits a complete line.
          if (last_word) begin
            meta_we    = 1'b1;
            meta_tag   = miss_tag_q;
            meta_dirty = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      cache_stall = 1'b0;
      ram_req     = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      wr_en       = 1'b0;
      meta_we     = 1'b0;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Random + directed bench for data_cache_controller: a behavioural cache/memory model predicts
// loads, RAM transfers and stall lengths; a negedge monitor checks DUT outputs against queues.
module tb_data_cache_controller;

  logic        clock, reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cache_stall;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  data_cache_controller dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cache_stall (cache_stall),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ram_exp_t;

  int tests = 0;
  int fails = 0;
  int acks_seen = 0;
  int mem_delay = 0;
  bit spurious_en = 0;

  ram_exp_t    ram_q[$];
  logic [31:0] load_q[$];

  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] mmem    [logic [31:0]];

  logic [23:0] m_tag   [16];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [31:0] m_data  [16][4];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mem(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  // Reference cache: whole-line granularity, write-back/allocate, stall = 1 + acks*(delay+1).
  task automatic model_access(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [31:0] wd, output int stall);
    int          idx, w, nacks;
    logic [23:0] tg;
    logic [31:0] a;
    stall = 0;
    if (!rd && !wr) return;
    idx = int'((addr / 16) % 16);
    w   = int'((addr / 4) % 4);
    tg  = 24'(addr / 256);
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      nacks = 4;
      if (m_valid[idx] && m_dirty[idx]) begin
        nacks = 8;
        for (int i = 0; i < 4; i++) begin
          a = m_tag[idx] * 256 + idx * 16 + i * 4;
          ram_q.push_back('{1'b1, a, m_data[idx][i]});
          mmem[a] = m_data[idx][i];
        end
      end
      for (int i = 0; i < 4; i++) begin
        a = tg * 256 + idx * 16 + i * 4;
        ram_q.push_back('{1'b0, a, 32'h0});
        m_data[idx][i] = model_mem(a);
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      stall = 1 + nacks * (mem_delay + 1);
    end
    if (wr) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1;
    end else begin
      load_q.push_back(m_data[idx][w]);
    end
  endtask

  // Memory responder: acks each held request after mem_delay wait cycles.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    ram_ack   = 1'b0;
    ram_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (ram_req) begin
        if (wait_cnt >= mem_delay) begin
          ram_ack  = 1'b1;
          wait_cnt = 0;
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
          else ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_word(ram_addr);
        end else begin
          ram_ack   = 1'b0;
          ram_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        ram_ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
        ram_rdata = $urandom;
      end
    end
  end

  // Monitor: every RAM cycle must match the head expectation; pop on ack; pop loads on completion.
  always @(negedge clock) begin
    if (!reset) begin
      if (ram_req) begin
        if (ram_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ram_unexpected: got req we=%0b addr %h, required no request", ram_we, ram_addr);
        end else begin
          check("ram_we", 32'(ram_we), 32'(ram_q[0].we));
          check("ram_addr", ram_addr, ram_q[0].addr);
          if (ram_q[0].we) check("ram_wdata", ram_wdata, ram_q[0].data);
          if (ram_ack) begin
            void'(ram_q.pop_front());
            acks_seen++;
          end
        end
      end
      if (cache_stall) check("rdata_zero_in_stall", cpu_rdata, 32'h0);
      else if (cpu_read && !cpu_write) begin
        if (load_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL load_unexpected: got rdata %h, required no load pending", cpu_rdata);
        end else begin
          check("load_rdata", cpu_rdata, load_q.pop_front());
        end
      end
    end
  end

  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wd);
    int exp_stall, n;
    model_access(addr, rd, wr, wd, exp_stall);
    @(posedge clock);
    #1;
    cpu_addr  = addr;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_wdata = wd;
    n = 0;
    forever begin
      @(negedge clock);
      if (!cache_stall) break;
      n++;
      if (n > 1000) begin
        tests++;
        fails++;
        $display("FAIL stall_timeout: stall still high after %0d cycles, required %0d", n, exp_stall);
        break;
      end
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clock);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic reset_mid_allocate(input logic [31:0] addr);
    int exp_stall, base, n;
    mem_delay   = 0;
    spurious_en = 0;
    model_access(addr, 1'b1, 1'b0, 32'h0, exp_stall);
    base = acks_seen;
    @(posedge clock);
    #1;
    cpu_addr = addr;
    cpu_read = 1'b1;
    n = 0;
    while (acks_seen < base + 2 && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("reset_ack_wait", 32'(acks_seen - base), 32'd2);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(negedge clock);
    check("stall_during_reset", 32'(cache_stall), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ram_q.delete();
    load_q.delete();
    model_reset();
    @(negedge clock);
    check("ram_req_after_reset", 32'(ram_req), 32'h0);
    do_access(addr, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [23:0] tg;
    int          op;
    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_wdata = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_stall", 32'(cache_stall), 32'h0);
    check("reset_ram_req", 32'(ram_req), 32'h0);
    check("reset_ram_we", 32'(ram_we), 32'h0);
    check("reset_ram_addr", ram_addr, 32'h0);
    check("reset_ram_wdata", ram_wdata, 32'h0);
    check("reset_rdata", cpu_rdata, 32'h0);

    do_access(32'h0000_0100, 1, 0, 0);
    do_access(32'h0000_0104, 1, 0, 0);
    do_access(32'h0000_0108, 0, 1, 32'hDEAD_BEEF);
    do_access(32'h0000_0108, 1, 0, 0);
    do_access(32'h0000_1100, 1, 0, 0);
    mem_delay = 5;
    do_access(32'h0000_2200, 1, 0, 0);
    do_access(32'h0000_2204, 0, 0, 0);
    mem_delay = 0;
    reset_mid_allocate(32'h0000_3330);
    spurious_en = 1;
    repeat (4) @(posedge clock);
    do_access(32'h0000_0340, 1, 1, 32'h1234_5678);
    do_access(32'h0000_0340, 1, 0, 0);
    do_access(32'h0000_0344, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      tg          = 24'($urandom_range(0, 3)) ^ ($urandom_range(0, 1) ? 24'hFFF000 : 24'h0);
      a           = {tg, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      mem_delay   = $urandom_range(0, 2);
      spurious_en = 1'($urandom_range(0, 1));
      op          = $urandom_range(0, 9);
      if (op == 0)      do_access(a, 0, 0, 0);
      else if (op <= 5) do_access(a, 1, 0, 0);
      else if (op <= 8) do_access(a, 0, 1, $urandom);
      else              do_access(a, 1, 1, $urandom);
    end

    repeat (3) @(negedge clock);
    check("ram_queue_drained", 32'(ram_q.size()), 32'h0);
    check("load_queue_drained", 32'(load_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
